// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block and its decoder.
// Latency: n/a (constants, types only).
// Backpressure: n/a.
package seg7_pkg;

   localparam int DIGITS = 8;

   // Active-high segment patterns g..a for hex values 0..F; the scanner encodes with the same table.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {
      SYNC,
      CAPTURE,
      PUBLISH
   } cap_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Maps a 7-bit segment pattern back to its hex nibble; flags patterns outside the table.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pat,
   output logic       valid,
   output logic [3:0] nibble
);

   // search the segment table; unknown patterns give nibble 0 with valid low
   always_comb begin
      valid  = 1'b0;
      nibble = 4'h0;
      for (int v = 0; v < 16; v++) begin
         if (pat == SEG_TABLE[v]) begin
            valid  = 1'b1;
            nibble = 4'(v);
         end
      end
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds 8 hex digits + decimal points from a scanned seg8/BT bus and publishes whole frames.
// Latency: a digit is sampled STABLE_CYCLES edges after it settles; frame_valid follows one edge later.
// Backpressure: frame held until frame_valid&&frame_ready; a frame completing while one is pending is dropped and flagged on overrun.
module seg_scan_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic        clk_i,
   input  logic        rst,
   input  logic [7:0]  seg8,
   input  logic [7:0]  BT,
   input  logic        frame_ready,
   output logic        frame_valid,
   output logic [31:0] digits_o,
   output logic [7:0]  dp_o,
   output logic [7:0]  bad_o,
   output logic        bt_err,
   output logic        overrun
);

   localparam logic [7:0] CNT_SAT  = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 1);

   logic [7:0]        s_seg;
   logic [7:0]        s_bt;
   logic [7:0]        cnt;
   logic              latched;
   logic              same;
   logic              sample_ev;
   logic              bt_onehot;

   logic              dec_valid;
   logic [3:0]        dec_nib;

   cap_state_t        state;
   cap_state_t        state_n;
   logic [DIGITS-1:0] mask;
   logic [DIGITS-1:0] mask_n;
   logic              wr_en;
   logic              publish;

   logic [3:0]        slot_nib [DIGITS];
   logic [DIGITS-1:0] slot_dp;
   logic [DIGITS-1:0] slot_bad;

   // a digit counts as present only once the bus has matched its previous value long enough
   assign same      = ({seg8, BT} == {s_seg, s_bt});
   assign sample_ev = same && (cnt == CNT_FIRE) && !latched;
   assign bt_onehot = $onehot(s_bt);

   // input sample register and dwell-stability counter; latched limits to one sample per dwell
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         s_seg   <= '0;
         s_bt    <= '0;
         cnt     <= '0;
         latched <= 1'b0;
      end else begin
         s_seg <= seg8;
         s_bt  <= BT;
         if (!same) begin
            cnt     <= '0;
            latched <= 1'b0;
         end else begin
            if (cnt != CNT_SAT) begin
               cnt <= cnt + 8'd1;
            end
            if (sample_ev) begin
               latched <= 1'b1;
            end
         end
      end
   end

   seg7_decode u_dec (
      .pat    (s_seg[6:0]),
      .valid  (dec_valid),
      .nibble (dec_nib)
   );

   // frame state and collected-digit mask
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         state <= SYNC;
         mask  <= '0;
      end else begin
         state <= state_n;
         mask  <= mask_n;
      end
   end

   // next state: wait for digit 0 to align, collect all eight slots, then publish for one cycle
   always_comb begin
      state_n = state;
      mask_n  = mask;
      wr_en   = 1'b0;
      publish = 1'b0;
      case (state)
         SYNC: begin
            if (sample_ev && (s_bt == 8'h01)) begin
               wr_en   = 1'b1;
               mask_n  = 8'h01;
               state_n = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sample_ev && bt_onehot) begin
               wr_en  = 1'b1;
               mask_n = mask | s_bt;
               if (mask_n == 8'hFF) begin
                  state_n = PUBLISH;
               end
            end
         end
         PUBLISH: begin
            publish = 1'b1;
            mask_n  = '0;
            state_n = SYNC;
         end
         default: begin
            state_n = SYNC;
            mask_n  = '0;
         end
      endcase
   end

   // slot storage: decoded nibble, bad flag and dp of the selected digit
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            slot_nib[i] <= 4'h0;
         end
         slot_dp  <= '0;
         slot_bad <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (s_bt[i]) begin
               slot_nib[i] <= dec_nib;
               slot_dp[i]  <= s_seg[7];
               slot_bad[i] <= !dec_valid;
            end
         end
      end
   end

   // frame outputs and handshake; a publish on the accepting edge keeps valid high with new data
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         frame_valid <= 1'b0;
         digits_o    <= '0;
         dp_o        <= '0;
         bad_o       <= '0;
         overrun     <= 1'b0;
      end else if (publish) begin
         if (!frame_valid || frame_ready) begin
            frame_valid <= 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
               digits_o[4*i +: 4] <= slot_nib[i];
            end
            dp_o  <= slot_dp;
            bad_o <= slot_bad;
         end else begin
            overrun <= 1'b1;
         end
      end else if (frame_valid && frame_ready) begin
         frame_valid <= 1'b0;
      end
   end

   // sticky flag for a settled, non-blank digit select that is not one-hot
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         bt_err <= 1'b0;
      end else if (sample_ev && (s_bt != 8'h00) && !bt_onehot) begin
         bt_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: dwell-level stimulus, frame-level reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: frame_ready driven constant low, constant high or random per phase.
module tb_seg_scan_capture;

   localparam int S = 4;

   logic        clk_i = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  seg8 = 8'h00;
   logic [7:0]  BT = 8'h00;
   logic        frame_ready = 1'b0;
   logic        frame_valid;
   logic [31:0] digits_o;
   logic [7:0]  dp_o;
   logic [7:0]  bad_o;
   logic        bt_err;
   logic        overrun;

   seg_scan_capture #(.STABLE_CYCLES(S)) dut (
      .clk_i       (clk_i),
      .rst         (rst),
      .seg8        (seg8),
      .BT          (BT),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .digits_o    (digits_o),
      .dp_o        (dp_o),
      .bad_o       (bad_o),
      .bt_err      (bt_err),
      .overrun     (overrun)
   );

   always #5 clk_i = ~clk_i;

   // independent copy of the segment patterns for values 0..F
   logic [6:0] ref_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   int          vectors = 0;
   int          miscompares = 0;
   int          ecount = 0;
   int          vld_cycles = 0;
   int          ready_mode = 0;
   int          t0 = 0;
   logic [15:0] last_app = 16'h0000;
   logic [15:0] sample_at [int];

   // reference model state
   logic        m_valid = 1'b0;
   logic [31:0] m_digits = '0;
   logic [7:0]  m_dp = '0;
   logic [7:0]  m_bad = '0;
   logic        m_bterr = 1'b0;
   logic        m_overrun = 1'b0;
   bit          m_collect = 1'b0;
   bit          m_pend = 1'b0;
   logic [7:0]  m_got = '0;
   logic [3:0]  m_nib [8];
   logic [7:0]  m_sdp = '0;
   logic [7:0]  m_sbad = '0;

   function automatic logic [7:0] enc(input logic [3:0] n, input logic dp);
      return {dp, ref_tab[n]};
   endfunction

   function automatic void model_sample(input logic [7:0] s, input logic [7:0] b, input bit busy);
      int         idx;
      logic [3:0] n;
      bit         ok;
      if (b == 8'h00) return;
      if (!$onehot(b)) begin
         m_bterr = 1'b1;
         return;
      end
      if (busy) return;
      if (!m_collect) begin
         if (b != 8'h01) return;
         m_collect = 1'b1;
         m_got     = 8'h00;
      end
      idx = 0;
      for (int i = 0; i < 8; i++) if (b[i]) idx = i;
      ok = 1'b0;
      n  = 4'h0;
      for (int v = 0; v < 16; v++) begin
         if (ref_tab[v] == s[6:0]) begin
            ok = 1'b1;
            n  = 4'(v);
         end
      end
      m_nib[idx]  = n;
      m_sdp[idx]  = s[7];
      m_sbad[idx] = !ok;
      m_got[idx]  = 1'b1;
      if (m_got == 8'hFF) m_pend = 1'b1;
   endfunction

   // model: advances once per edge using the scheduled sample events and frame_ready
   initial begin
      logic [15:0] ev;
      bit          has_ev;
      bit          was_pend;
      forever begin
         @(posedge clk_i);
         ecount++;
         has_ev = sample_at.exists(ecount);
         ev     = 16'h0000;
         if (has_ev) begin
            ev = sample_at[ecount];
            sample_at.delete(ecount);
         end
         if (!rst) begin
            m_valid = 1'b0; m_digits = '0; m_dp = '0; m_bad = '0;
            m_bterr = 1'b0; m_overrun = 1'b0;
            m_collect = 1'b0; m_pend = 1'b0; m_got = '0;
            m_sdp = '0; m_sbad = '0;
            for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
         end else begin
            was_pend = m_pend;
            if (m_pend) begin
               if (!m_valid || frame_ready) begin
                  m_valid = 1'b1;
                  for (int i = 0; i < 8; i++) m_digits[4*i +: 4] = m_nib[i];
                  m_dp  = m_sdp;
                  m_bad = m_sbad;
               end else begin
                  m_overrun = 1'b1;
               end
               m_pend    = 1'b0;
               m_collect = 1'b0;
               m_got     = 8'h00;
            end else if (m_valid && frame_ready) begin
               m_valid = 1'b0;
            end
            if (has_ev) model_sample(ev[15:8], ev[7:0], was_pend);
         end
      end
   end

   // compare DUT against model on every falling edge
   initial forever begin
      @(negedge clk_i);
      if (ecount > 0) begin
         vectors++;
         if (frame_valid !== m_valid || digits_o !== m_digits || dp_o !== m_dp ||
             bad_o !== m_bad || bt_err !== m_bterr || overrun !== m_overrun) begin
            miscompares++;
            $display("FAIL cycle %0d: dut v=%b d=%h dp=%h bad=%h bterr=%b ovr=%b, model v=%b d=%h dp=%h bad=%h bterr=%b ovr=%b",
                     ecount, frame_valid, digits_o, dp_o, bad_o, bt_err, overrun,
                     m_valid, m_digits, m_dp, m_bad, m_bterr, m_overrun);
         end
         if (frame_valid === 1'b1) vld_cycles++;
      end
   end

   // frame_ready driver
   initial forever begin
      @(posedge clk_i);
      #2;
      case (ready_mode)
         0:       frame_ready = 1'b0;
         1:       frame_ready = 1'b1;
         default: frame_ready = 1'($urandom_range(0, 1));
      endcase
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // present {s,b} for len edges; a dwell of at least S+1 edges yields one sample at t0+S
   task automatic apply(input logic [7:0] s, input logic [7:0] b, input int len);
      seg8     = s;
      BT       = b;
      t0       = ecount + 1;
      last_app = {s, b};
      if (len >= S + 1) sample_at[t0 + S] = {s, b};
      hold(len);
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b0;
      seg8     = 8'h00;
      BT       = 8'h00;
      last_app = 16'h0000;
      hold(n);
      rst = 1'b1;
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      int          v0;
      int          r;
      int          len;
      int          k;
      logic [7:0]  s;
      logic [7:0]  b;

      // reset state
      rst = 1'b0;
      hold(3);
      lit("reset_valid", 32'(frame_valid), 32'h0);
      lit("reset_digits", digits_o, 32'h0);
      lit("reset_dp", 32'(dp_o), 32'h0);
      lit("reset_bad", 32'(bad_o), 32'h0);
      lit("reset_bterr", 32'(bt_err), 32'h0);
      lit("reset_overrun", 32'(overrun), 32'h0);
      rst = 1'b1;

      // basic pass: values 1..8 on digits 0..7
      ready_mode = 1;
      v0 = vld_cycles;
      for (int i = 0; i < 8; i++) apply(enc(4'(i + 1), 1'b0), 8'(1 << i), 10);
      apply(8'h00, 8'h00, 6);
      lit("basic_digits", digits_o, 32'h87654321);
      lit("basic_dp", 32'(dp_o), 32'h0);
      lit("basic_bad", 32'(bad_o), 32'h0);
      lit("basic_pulses", 32'(vld_cycles - v0), 32'd1);

      // digit 3 too short to sample, then long enough: publish one edge after its sample
      v0 = vld_cycles;
      for (int i = 0; i < 8; i++) apply(enc(4'(i), 1'b0), 8'(1 << i), (i == 3) ? S : 8);
      apply(8'h00, 8'h00, 6);
      lit("short_no_frame", 32'(vld_cycles - v0), 32'd0);
      for (int i = 0; i < 3; i++) apply(enc(4'(i), 1'b0), 8'(1 << i), 8);
      apply(enc(4'd3, 1'b0), 8'h08, S + 1);
      lit("latency_before", 32'(frame_valid), 32'h0);
      apply(enc(4'd4, 1'b0), 8'h10, 1);
      lit("latency_rise", 32'(frame_valid), 32'h1);
      lit("latency_digits", digits_o, 32'h76543210);
      for (int i = 5; i < 8; i++) apply(enc(4'(i), 1'b0), 8'(1 << i), 8);

      // scan starting at digit 4 after reset: only the later full pass is captured
      do_reset(2);
      for (int i = 4; i < 8; i++) apply(enc(4'd1, 1'b0), 8'(1 << i), 8);
      for (int i = 0; i < 8; i++) apply(enc(4'(8 + i), 1'b0), 8'(1 << i), 8);
      apply(8'h00, 8'h00, 6);
      lit("midstart_digits", digits_o, 32'hFEDCBA98);

      // unknown pattern on digit 5, dp on digit 2
      for (int i = 0; i < 8; i++) begin
         s = enc(4'(i), 1'b0);
         if (i == 2) s = 8'h86;
         if (i == 5) s = 8'h7E;
         apply(s, 8'(1 << i), 8);
      end
      apply(8'h00, 8'h00, 6);
      lit("bad_mask", 32'(bad_o), 32'h20);
      lit("bad_dp", 32'(dp_o), 32'h04);
      lit("bad_digits", digits_o, 32'h76043110);

      // multi-hot digit select inside an otherwise good pass
      for (int i = 0; i < 8; i++) begin
         apply(enc(4'(i), 1'b0), 8'(1 << i), 8);
         if (i == 3) apply(enc(4'd5, 1'b0), 8'h03, 6);
      end
      apply(8'h00, 8'h00, 6);
      lit("bterr_set", 32'(bt_err), 32'h1);
      lit("bterr_frame", digits_o, 32'h76543210);

      // no consumer through two passes: first frame held, second dropped
      ready_mode = 0;
      for (int i = 0; i < 8; i++) apply(enc(4'(i + 1), 1'b1), 8'(1 << i), 8);
      for (int i = 0; i < 8; i++) apply(enc(4'(15 - i), 1'b0), 8'(1 << i), 8);
      apply(8'h00, 8'h00, 6);
      lit("ovr_flag", 32'(overrun), 32'h1);
      lit("ovr_valid", 32'(frame_valid), 32'h1);
      lit("ovr_digits", digits_o, 32'h87654321);
      lit("ovr_dp", 32'(dp_o), 32'hFF);
      lit("bterr_sticky", 32'(bt_err), 32'h1);
      ready_mode = 1;
      hold(1);
      lit("drop_after_ready", 32'(frame_valid), 32'h0);

      // reset in the middle of a pass
      for (int i = 0; i < 4; i++) apply(enc(4'(i), 1'b0), 8'(1 << i), 8);
      rst      = 1'b0;
      seg8     = 8'h00;
      BT       = 8'h00;
      last_app = 16'h0000;
      hold(1);
      lit("midrst_valid", 32'(frame_valid), 32'h0);
      lit("midrst_digits", digits_o, 32'h0);
      lit("midrst_flags", {30'h0, bt_err, overrun}, 32'h0);
      hold(1);
      rst = 1'b1;

      // randomized dwells, selects, segment patterns, backpressure and resets
      ready_mode = 2;
      k = 7;
      for (int n = 0; n < 800; n++) begin
         r   = $urandom_range(0, 99);
         len = $urandom_range(1, S + 6);
         s   = enc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (r < 2) begin
            do_reset($urandom_range(1, 2));
            continue;
         end else if (r < 72) begin
            k = (k + 1) % 8;
            b = 8'(1 << k);
            if ($urandom_range(0, 19) == 0) s = 8'($urandom_range(0, 255));
         end else if (r < 82) begin
            b = 8'h00;
         end else if (r < 92) begin
            b = 8'(1 << $urandom_range(0, 7));
         end else begin
            b = 8'($urandom_range(1, 255));
         end
         if ({s, b} == last_app) s = s ^ 8'h01;
         apply(s, b, len);
      end
      apply(8'h00, 8'h00, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
